// File: rtl/mips_pkg.sv
// Shared types and widths for the five-stage MIPS core.
// Writeback source and load width/sign encodings match the MEM-stage control fields.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_LINK = 2'd2
  } wb_sel_t;

  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_H  = 3'd1,
    LD_HU = 3'd2,
    LD_B  = 3'd3,
    LD_BU = 3'd4
  } load_type_t;

endpackage

// File: rtl/load_align.sv
// Big-endian sub-word load alignment and sign/zero extension.
// Purely combinational; also reports whether the access is misaligned for its width.
module load_align
  import mips_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  input  logic [1:0]        offset,
  input  load_type_t        load_type,
  output logic [DATA_W-1:0] aligned,
  output logic              misaligned
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  // Byte 0 is the most significant byte of the word.
  always_comb begin
    case (offset)
      2'd0:    byte_val = data[31:24];
      2'd1:    byte_val = data[23:16];
      2'd2:    byte_val = data[15:8];
      default: byte_val = data[7:0];
    endcase
    half_val = offset[1] ? data[15:0] : data[31:16];
  end

  // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    aligned    = data;
    misaligned = (offset != 2'd0);
    case (load_type)
      LD_H: begin
        aligned    = {{16{half_val[15]}}, half_val};
        misaligned = offset[0];
      end
      LD_HU: begin
        aligned    = {16'd0, half_val};
        misaligned = offset[0];
      end
      LD_B: begin
        aligned    = {{24{byte_val[7]}}, byte_val};
        misaligned = 1'b0;
      end
      LD_BU: begin
        aligned    = {24'd0, byte_val};
        misaligned = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: selects the writeback value, drives the register file
// write port from flops, flags misaligned loads and counts retired instructions.
module mem_wb_stage
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              mem_valid,
  input  logic [REG_W-1:0]  mem_rd,
  input  logic              mem_reg_write,
  input  logic [1:0]        mem_wb_sel,
  input  logic [2:0]        mem_load_type,
  input  logic [1:0]        mem_addr_lo,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [DATA_W-1:0] mem_load_data,
  input  logic [DATA_W-1:0] mem_pc_plus8,
  output logic [REG_W-1:0]  write_register,
  output logic [DATA_W-1:0] write_data,
  output logic              write_enable,
  output logic              wb_valid,
  output logic              misalign_exc,
  output logic [DATA_W-1:0] retire_count
);

  wb_sel_t           sel;
  load_type_t        load_type;
  logic [DATA_W-1:0] aligned;
  logic [DATA_W-1:0] wb_value;
  logic              misaligned;
  logic              load_fault;
  logic              we_next;

  // Unlisted codes fall through to the ALU / LW defaults below.
  assign sel       = wb_sel_t'(mem_wb_sel);
  assign load_type = load_type_t'(mem_load_type);

  load_align u_load_align (
    .data       (mem_load_data),
    .offset     (mem_addr_lo),
    .load_type  (load_type),
    .aligned    (aligned),
    .misaligned (misaligned)
  );

  always_comb begin
    wb_value = mem_alu_result;
    case (sel)
      WB_LOAD: wb_value = aligned;
      WB_LINK: wb_value = mem_pc_plus8;
      default: ;
    endcase
  end

  // Only a load can fault; the address bits of other instructions are ALU result bits.
  assign load_fault = misaligned & (sel == WB_LOAD);
  assign we_next    = mem_valid & mem_reg_write & (mem_rd != '0) & ~load_fault;

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_register <= '0;
      write_data     <= '0;
      write_enable   <= 1'b0;
      wb_valid       <= 1'b0;
      misalign_exc   <= 1'b0;
      retire_count   <= '0;
    end else if (flush) begin
      // Bubble: control bits drop, data fields are don't-care and simply hold.
      write_enable   <= 1'b0;
      wb_valid       <= 1'b0;
      misalign_exc   <= 1'b0;
    end else if (!stall) begin
      write_register <= mem_rd;
      write_data     <= wb_value;
      write_enable   <= we_next;
      wb_valid       <= mem_valid;
      misalign_exc   <= load_fault & mem_valid;
      if (mem_valid) retire_count <= retire_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus randomized traffic
// compared against a behavioural model of the writeback rules.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        mem_valid = 1'b0;
  logic [4:0]  mem_rd = '0;
  logic        mem_reg_write = 1'b0;
  logic [1:0]  mem_wb_sel = '0;
  logic [2:0]  mem_load_type = '0;
  logic [1:0]  mem_addr_lo = '0;
  logic [31:0] mem_alu_result = '0;
  logic [31:0] mem_load_data = '0;
  logic [31:0] mem_pc_plus8 = '0;
  logic [4:0]  write_register;
  logic [31:0] write_data;
  logic        write_enable;
  logic        wb_valid;
  logic        misalign_exc;
  logic [31:0] retire_count;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [4:0]  m_wr = '0;
  logic [31:0] m_wd = '0;
  logic        m_we = 1'b0;
  logic        m_valid = 1'b0;
  logic        m_exc = 1'b0;
  logic [31:0] m_count = '0;
  bit          m_known = 1'b1;

  localparam logic [71:0] FLAG_MASK = {37'd0, {35{1'b1}}};

  mem_wb_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .flush          (flush),
    .mem_valid      (mem_valid),
    .mem_rd         (mem_rd),
    .mem_reg_write  (mem_reg_write),
    .mem_wb_sel     (mem_wb_sel),
    .mem_load_type  (mem_load_type),
    .mem_addr_lo    (mem_addr_lo),
    .mem_alu_result (mem_alu_result),
    .mem_load_data  (mem_load_data),
    .mem_pc_plus8   (mem_pc_plus8),
    .write_register (write_register),
    .write_data     (write_data),
    .write_enable   (write_enable),
    .wb_valid       (wb_valid),
    .misalign_exc   (misalign_exc),
    .retire_count   (retire_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  function automatic logic [71:0] outs();
    return {write_register, write_data, write_enable, wb_valid, misalign_exc, retire_count};
  endfunction

  function automatic logic [71:0] model_outs();
    return {m_wr, m_wd, m_we, m_valid, m_exc, m_count};
  endfunction

  // Loaded value from shifting the big-endian word and extending arithmetically.
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] off,
                                           input logic [2:0] t);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * (3 - int'(off)))) & 32'hFF;
    h = (w >> (off[1] ? 0 : 16)) & 32'hFFFF;
    case (t)
      3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd2:    return h;
      3'd3:    return (b >= 32'd128) ? b - 32'd256 : b;
      3'd4:    return b;
      default: return w;
    endcase
  endfunction

  function automatic bit ref_misaligned(input logic [1:0] off, input logic [2:0] t);
    if (t == 3'd1 || t == 3'd2) return (int'(off) % 2) == 1;
    if (t == 3'd3 || t == 3'd4) return 1'b0;
    return off != 2'd0;
  endfunction

  task automatic set_op(input bit v, input bit rw, input logic [4:0] rd, input logic [1:0] sel,
                        input logic [2:0] lt, input logic [1:0] lo, input logic [31:0] alu,
                        input logic [31:0] ld, input logic [31:0] pc);
    mem_valid      = v;
    mem_reg_write  = rw;
    mem_rd         = rd;
    mem_wb_sel     = sel;
    mem_load_type  = lt;
    mem_addr_lo    = lo;
    mem_alu_result = alu;
    mem_load_data  = ld;
    mem_pc_plus8   = pc;
  endtask

  // Advance one rising edge, update the model from the pre-edge inputs, sample #1 later.
  task automatic tick();
    bit mis;
    if (flush) begin
      m_valid = 1'b0;
      m_we    = 1'b0;
      m_exc   = 1'b0;
      m_known = 1'b0;
    end else if (!stall) begin
      mis     = (mem_wb_sel == 2'd1) && ref_misaligned(mem_addr_lo, mem_load_type);
      m_wr    = mem_rd;
      m_wd    = (mem_wb_sel == 2'd1) ? ref_load(mem_load_data, mem_addr_lo, mem_load_type) :
                (mem_wb_sel == 2'd2) ? mem_pc_plus8 : mem_alu_result;
      m_valid = mem_valid;
      m_we    = mem_valid && mem_reg_write && (mem_rd != 0) && !mis;
      m_exc   = mem_valid && mis;
      if (mem_valid) m_count = m_count + 1;
      m_known = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_wr = '0; m_wd = '0; m_we = 1'b0; m_valid = 1'b0; m_exc = 1'b0; m_count = '0;
    m_known = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (outs() !== 72'd0) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", outs(), 72'd0);
    end
    #9 rst_n = 1'b1;
  endtask

  task automatic test_alu();
    set_op(1, 1, 5'd5, 2'd0, 3'd0, 2'd0, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0);
    tick();
    checks++;
    if (write_register !== 5'd5) begin
      errors++; $display("FAIL alu_wr: got %0d expected 5", write_register);
    end
    checks++;
    if (write_data !== 32'h1234_5678) begin
      errors++; $display("FAIL alu_wd: got %h expected 12345678", write_data);
    end
    checks++;
    if (write_enable !== 1'b1 || wb_valid !== 1'b1) begin
      errors++; $display("FAIL alu_we: got we=%b valid=%b expected 1 1", write_enable, wb_valid);
    end
    checks++;
    if (retire_count !== 32'd1) begin
      errors++; $display("FAIL alu_count: got %0d expected 1", retire_count);
    end
  endtask

  task automatic test_load_align();
    logic [2:0]  lts [4] = '{3'd3, 3'd4, 3'd1, 3'd1};
    logic [1:0]  los [4] = '{2'd0, 2'd0, 2'd2, 2'd0};
    logic [31:0] exps[4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_7F01, 32'hFFFF_80FF};
    for (int i = 0; i < 4; i++) begin
      set_op(1, 1, 5'd7, 2'd1, lts[i], los[i], 32'h0, 32'h80FF_7F01, 32'h0);
      tick();
      checks++;
      if (write_data !== exps[i] || write_enable !== 1'b1 || misalign_exc !== 1'b0) begin
        errors++;
        $display("FAIL load_align[%0d]: got data=%h we=%b exc=%b expected data=%h we=1 exc=0",
                 i, write_data, write_enable, misalign_exc, exps[i]);
      end
    end
  endtask

  task automatic test_misalign();
    logic [2:0] lts[2] = '{3'd0, 3'd1};
    logic [1:0] los[2] = '{2'd2, 2'd1};
    for (int i = 0; i < 2; i++) begin
      set_op(1, 1, 5'd8, 2'd1, lts[i], los[i], 32'h0, 32'hA5A5_5A5A, 32'h0);
      tick();
      checks++;
      if (misalign_exc !== 1'b1) begin
        errors++; $display("FAIL misalign_exc[%0d]: got %b expected 1", i, misalign_exc);
      end
      checks++;
      if (write_enable !== 1'b0) begin
        errors++; $display("FAIL misalign_we[%0d]: got %b expected 0", i, write_enable);
      end
      checks++;
      if (retire_count !== m_count) begin
        errors++; $display("FAIL misalign_count[%0d]: got %0d expected %0d", i, retire_count, m_count);
      end
    end
  endtask

  task automatic test_link();
    set_op(1, 1, 5'd31, 2'd2, 3'd0, 2'd0, 32'h1111_1111, 32'h0, 32'h0040_0010);
    tick();
    checks++;
    if (write_data !== 32'h0040_0010 || write_register !== 5'd31) begin
      errors++;
      $display("FAIL link_data: got rd=%0d data=%h expected rd=31 data=00400010", write_register, write_data);
    end
    checks++;
    if (write_enable !== 1'b1) begin
      errors++; $display("FAIL link_we: got %b expected 1", write_enable);
    end
    mem_rd = 5'd0;
    tick();
    checks++;
    if (write_enable !== 1'b0 || wb_valid !== 1'b1) begin
      errors++; $display("FAIL link_r0: got we=%b valid=%b expected we=0 valid=1", write_enable, wb_valid);
    end
  endtask

  task automatic test_stall_flush();
    logic [71:0] snap;
    set_op(1, 1, 5'd9, 2'd0, 3'd0, 2'd0, 32'hCAFE_F00D, 32'h0, 32'h0);
    tick();
    snap = model_outs();
    stall = 1'b1;
    set_op(1, 1, 5'd12, 2'd2, 3'd0, 2'd0, 32'h0, 32'h0, 32'h1234_0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (outs() !== snap) begin
        errors++; $display("FAIL stall_hold[%0d]: got %h expected %h", i, outs(), snap);
      end
    end
    flush = 1'b1;
    tick();
    checks++;
    if (wb_valid !== 1'b0 || write_enable !== 1'b0 || misalign_exc !== 1'b0 || retire_count !== snap[31:0]) begin
      errors++;
      $display("FAIL stall_flush: got valid=%b we=%b exc=%b count=%0d expected 0 0 0 %0d",
               wb_valid, write_enable, misalign_exc, retire_count, snap[31:0]);
    end
    stall = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_random();
    logic [1:0] sel;
    logic [71:0] mask;
    for (int i = 0; i < 300; i++) begin
      sel = 2'($urandom_range(0, 3));
      if (sel == 2'd1)
        set_op(1'($urandom), 1'($urandom), 5'($urandom), sel, 3'($urandom_range(0, 7)),
               2'($urandom), $urandom, $urandom, $urandom);
      else
        set_op(1'($urandom), 1'($urandom), 5'($urandom), sel, 3'd0, 2'd0,
               $urandom, $urandom, $urandom);
      if ($urandom_range(0, 7) == 0) mem_rd = 5'd0;
      stall = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 9) == 0);
      tick();
      mask = m_known ? {72{1'b1}} : FLAG_MASK;
      checks++;
      if ((outs() & mask) !== (model_outs() & mask)) begin
        errors++;
        $display("FAIL random[%0d]: got %h expected %h (mask %h)", i, outs(), model_outs(), mask);
      end
    end
    stall = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_async_reset();
    set_op(1, 1, 5'd3, 2'd0, 3'd0, 2'd0, 32'h5555_AAAA, 32'h0, 32'h0);
    tick();
    checks++;
    if (write_enable !== 1'b1) begin
      errors++; $display("FAIL async_pre_we: got %b expected 1", write_enable);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (outs() !== 72'd0) begin
      errors++; $display("FAIL async_reset: got %h expected %h", outs(), 72'd0);
    end
    model_reset();
    set_op(0, 0, 5'd0, 2'd0, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0);
    #1 rst_n = 1'b1;
    tick();
    checks++;
    if (write_enable !== 1'b0 || retire_count !== 32'd0) begin
      errors++;
      $display("FAIL async_after: got we=%b count=%0d expected we=0 count=0", write_enable, retire_count);
    end
  endtask

  task automatic test_wrap();
    force dut.retire_count = 32'hFFFF_FFFE;
    #1 release dut.retire_count;
    m_count = 32'hFFFF_FFFE;
    set_op(1, 1, 5'd4, 2'd0, 3'd0, 2'd0, 32'h1, 32'h0, 32'h0);
    tick();
    checks++;
    if (retire_count !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL wrap_pre: got %h expected ffffffff", retire_count);
    end
    tick();
    checks++;
    if (retire_count !== 32'h0000_0000) begin
      errors++; $display("FAIL wrap: got %h expected 00000000", retire_count);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_align();
    test_misalign();
    test_link();
    test_stall_flush();
    test_random();
    test_async_reset();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
